// File: rtl/board_io_pkg.sv
// Shared types and default parameter values for the board I/O controller.
package board_io_pkg;

   typedef enum logic [1:0] {
      LED_DIRECT = 2'd0,
      LED_DIM    = 2'd1,
      LED_BLINK  = 2'd2,
      LED_OFF    = 2'd3
   } led_mode_t;

   localparam int DEF_NUM_SW         = 16;
   localparam int DEF_NUM_BTN        = 5;
   localparam int DEF_NUM_LED        = 16;
   localparam int DEF_DEBOUNCE_CYC   = 1000000;
   localparam int DEF_RST_HOLD_CYC   = 16;
   localparam int DEF_PWM_BITS       = 8;
   localparam int DEF_BLINK_DIV_LOG2 = 24;

endpackage

// File: rtl/io_debounce.sv
// One debounced input channel: 2-flop synchronizer, stability counter, output flop.
module io_debounce #(
   parameter int DEBOUNCE_CYC = 8
) (
   input  logic clk_i,
   input  logic arst_n_i,
   input  logic d_i,
   output logic q_o
);

   localparam int CW = $clog2(DEBOUNCE_CYC + 1);
   localparam logic [CW-1:0] TC = CW'(DEBOUNCE_CYC - 1);

   logic          meta_q, sync_q, out_q, out_d;
   logic [CW-1:0] cnt_q, cnt_d;

   // The counter only runs while the synced input disagrees with the output,
   // so any disagreement shorter than DEBOUNCE_CYC samples is dropped.
   always_comb begin
      cnt_d = cnt_q;
      out_d = out_q;
      if (sync_q == out_q) begin
         cnt_d = '0;
      end else if (cnt_q == TC) begin
         cnt_d = '0;
         out_d = ~out_q;
      end else begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk_i or negedge arst_n_i) begin
      if (!arst_n_i) begin
         meta_q <= 1'b0;
         sync_q <= 1'b0;
         cnt_q  <= '0;
         out_q  <= 1'b0;
      end else begin
         meta_q <= d_i;
         sync_q <= meta_q;
         cnt_q  <= cnt_d;
         out_q  <= out_d;
      end
   end

   assign q_o = out_q;

endmodule

// File: rtl/board_io_ctrl.sv
// Board I/O controller: SoC reset sequencing, switch/button debounce, LED drive.
module board_io_ctrl
   import board_io_pkg::*;
#(
   parameter int NUM_SW         = DEF_NUM_SW,
   parameter int NUM_BTN        = DEF_NUM_BTN,
   parameter int NUM_LED        = DEF_NUM_LED,
   parameter int DEBOUNCE_CYC   = DEF_DEBOUNCE_CYC,
   parameter int RST_HOLD_CYC   = DEF_RST_HOLD_CYC,
   parameter int PWM_BITS       = DEF_PWM_BITS,
   parameter int BLINK_DIV_LOG2 = DEF_BLINK_DIV_LOG2
) (
   input  logic                clk_i,
   input  logic                arst_n_i,
   input  logic                pll_locked_i,
   input  logic [NUM_SW-1:0]   sw_i,
   input  logic [NUM_BTN-1:0]  btn_i,
   input  logic [NUM_LED-1:0]  led_i,
   input  logic [1:0]          led_mode_i,
   input  logic [PWM_BITS-1:0] bright_i,
   output logic                rst_o,
   output logic [NUM_SW-1:0]   sw_o,
   output logic [NUM_BTN-1:0]  btn_o,
   output logic [NUM_BTN-1:0]  btn_press_o,
   output logic [NUM_LED-1:0]  led_o
);

   localparam int NUM_CH = NUM_SW + NUM_BTN;
   localparam int HW     = $clog2(RST_HOLD_CYC + 1);
   localparam logic [HW-1:0] HOLD_TC = HW'(RST_HOLD_CYC - 1);

   // Either cause forces the SoC reset immediately; release is synchronous.
   logic          rst_src_n;
   logic          lock_meta_q, lock_sync_q;
   logic [HW-1:0] hold_q;
   logic          rst_q;

   assign rst_src_n = arst_n_i & pll_locked_i;

   always_ff @(posedge clk_i or negedge rst_src_n) begin
      if (!rst_src_n) begin
         lock_meta_q <= 1'b0;
         lock_sync_q <= 1'b0;
         hold_q      <= '0;
         rst_q       <= 1'b1;
      end else begin
         lock_meta_q <= pll_locked_i;
         lock_sync_q <= lock_meta_q;
         if (lock_sync_q && rst_q) begin
            if (hold_q == HOLD_TC) begin
               rst_q <= 1'b0;
            end else begin
               hold_q <= hold_q + 1'b1;
            end
         end
      end
   end

   assign rst_o = rst_q;

   // Debounce is cleared by the board reset only, so switch state survives lock loss.
   logic [NUM_CH-1:0] raw, deb;
   assign raw = {btn_i, sw_i};

   for (genvar g = 0; g < NUM_CH; g++) begin : g_deb
      io_debounce #(
         .DEBOUNCE_CYC (DEBOUNCE_CYC)
      ) u_deb (
         .clk_i    (clk_i),
         .arst_n_i (arst_n_i),
         .d_i      (raw[g]),
         .q_o      (deb[g])
      );
   end

   assign sw_o  = deb[NUM_SW-1:0];
   assign btn_o = deb[NUM_CH-1:NUM_SW];

   logic [NUM_BTN-1:0] btn_prev_q;
   assign btn_press_o = btn_o & ~btn_prev_q;

   logic [PWM_BITS-1:0]       pwm_q;
   logic [BLINK_DIV_LOG2-1:0] blink_q;
   logic                      blink_ph;
   logic [NUM_LED-1:0]        led_q, led_d;

   assign blink_ph = blink_q[BLINK_DIV_LOG2-1];

   always_comb begin
      led_d = '0;
      if (rst_q) begin
         led_d = {NUM_LED{blink_ph}};
      end else begin
         case (led_mode_t'(led_mode_i))
            LED_DIRECT: led_d = led_i;
            LED_DIM:    led_d = led_i & {NUM_LED{pwm_q < bright_i}};
            LED_BLINK:  led_d = led_i & {NUM_LED{blink_ph}};
            LED_OFF:    led_d = '0;
         endcase
      end
   end

   always_ff @(posedge clk_i or negedge arst_n_i) begin
      if (!arst_n_i) begin
         pwm_q      <= '0;
         blink_q    <= '0;
         led_q      <= '0;
         btn_prev_q <= '0;
      end else begin
         pwm_q      <= pwm_q + 1'b1;
         blink_q    <= blink_q + 1'b1;
         led_q      <= led_d;
         btn_prev_q <= btn_o;
      end
   end

   assign led_o = led_q;

endmodule

// File: tb/tb_board_io_ctrl.sv
// Self-checking bench for board_io_ctrl with a cycle-level behavioural reference model.
module tb_board_io_ctrl;

   localparam int NSW = 16, NBTN = 5, NLED = 16, NCH = 21;
   localparam int DB = 8, HOLD = 4;

   logic        clk = 1'b0;
   logic        arst_n, lock;
   logic [15:0] sw_i, led_i;
   logic [4:0]  btn_i;
   logic [1:0]  mode;
   logic [3:0]  bright;
   logic        rst_o;
   logic [15:0] sw_o, led_o;
   logic [4:0]  btn_o, btn_press_o;

   board_io_ctrl #(
      .NUM_SW(NSW), .NUM_BTN(NBTN), .NUM_LED(NLED), .DEBOUNCE_CYC(DB),
      .RST_HOLD_CYC(HOLD), .PWM_BITS(4), .BLINK_DIV_LOG2(4)
   ) dut (
      .clk_i(clk), .arst_n_i(arst_n), .pll_locked_i(lock), .sw_i(sw_i),
      .btn_i(btn_i), .led_i(led_i), .led_mode_i(mode), .bright_i(bright),
      .rst_o(rst_o), .sw_o(sw_o), .btn_o(btn_o), .btn_press_o(btn_press_o),
      .led_o(led_o)
   );

   always #5 clk = ~clk;

   int ncmp = 0, nfail = 0;

   // Reference model: n = cycles since board reset release, run = consecutive
   // clock edges with lock held, hist[j] = raw {btn,sw} sampled j edges ago.
   int              n, run;
   logic [NCH-1:0]  hist [10];
   logic [NCH-1:0]  m_out;
   logic [NBTN-1:0] m_press;
   logic [15:0]     m_led;
   logic            m_rst;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      ncmp++;
      assert (obs === exp) else begin
         nfail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      n = 0; run = 0;
      for (int j = 0; j < 10; j++) hist[j] = '0;
      m_out = '0; m_press = '0; m_led = '0; m_rst = 1'b1;
   endtask

   task automatic check_all();
      chk("rst_o", {31'd0, rst_o}, {31'd0, m_rst});
      chk("sw_o", {16'd0, sw_o}, {16'd0, m_out[15:0]});
      chk("btn_o", {27'd0, btn_o}, {27'd0, m_out[20:16]});
      chk("btn_press_o", {27'd0, btn_press_o}, {27'd0, m_press});
      chk("led_o", {16'd0, led_o}, {16'd0, m_led});
   endtask

   task automatic step();
      int   ph;
      logic blink, in_rst, all_diff;
      @(posedge clk);
      #1;
      if (!arst_n) begin
         model_reset();
      end else begin
         ph     = n % 16;
         blink  = (ph >= 8);
         in_rst = !lock || (run < 2 + HOLD);
         if (in_rst) m_led = {16{blink}};
         else begin
            case (mode)
               2'd0:    m_led = led_i;
               2'd1:    m_led = (ph < int'(bright)) ? led_i : 16'h0;
               2'd2:    m_led = blink ? led_i : 16'h0;
               default: m_led = 16'h0;
            endcase
         end
         n++;
         run = lock ? run + 1 : 0;
         for (int j = 9; j > 0; j--) hist[j] = hist[j-1];
         hist[0] = {btn_i, sw_i};
         m_press = '0;
         // Output flips once the last DB synchronized samples all disagree with it.
         for (int b = 0; b < NCH; b++) begin
            all_diff = 1'b1;
            for (int j = 2; j < 2 + DB; j++)
               if (hist[j][b] == m_out[b]) all_diff = 1'b0;
            if (all_diff) begin
               m_out[b] = ~m_out[b];
               if (b >= NSW && m_out[b]) m_press[b-NSW] = 1'b1;
            end
         end
         m_rst = !lock || (run < 2 + HOLD);
      end
      check_all();
   endtask

   task automatic set_lock(input logic v);
      lock = v;
      #1;
      if (!v) begin
         run   = 0;
         m_rst = 1'b1;
         chk("rst_async_lock", {31'd0, rst_o}, 32'd1);
      end
   endtask

   initial begin
      int   cnt, tg, bad, hold;
      logic prev;
      arst_n = 1'b1; lock = 1'b1; sw_i = '0; btn_i = '0; led_i = '0;
      mode = 2'd0; bright = '0;
      model_reset();
      #1 arst_n = 1'b0;
      #1 check_all();
      repeat (3) step();
      arst_n = 1'b1;

      repeat (5) step();
      chk("rel_5", {31'd0, rst_o}, 32'd1);
      step();
      chk("rel_6", {31'd0, rst_o}, 32'd0);

      sw_i[3] = 1'b1;
      repeat (9) step();
      chk("db_9", {31'd0, sw_o[3]}, 32'd0);
      step();
      chk("db_10", {31'd0, sw_o[3]}, 32'd1);

      sw_i[5] = 1'b1;
      repeat (7) step();
      sw_i[5] = 1'b0;
      repeat (12) step();
      chk("glitch7", {31'd0, sw_o[5]}, 32'd0);

      btn_i[0] = 1'b1; cnt = 0;
      repeat (20) begin step(); cnt += int'(btn_press_o[0]); end
      chk("press_hi", cnt, 1);
      btn_i[0] = 1'b0; cnt = 0;
      repeat (20) begin step(); cnt += int'(btn_press_o[0]); end
      chk("press_rel", cnt, 0);
      chk("btn_rel", {31'd0, btn_o[0]}, 32'd0);

      led_i = 16'hFFFF; mode = 2'd1; bright = 4'd4;
      step(); cnt = 0;
      repeat (16) begin step(); if (led_o == 16'hFFFF) cnt++; end
      chk("dim4", cnt, 4);
      bright = 4'd0;
      step(); cnt = 0;
      repeat (16) begin step(); if (led_o != 16'h0) cnt++; end
      chk("dim0", cnt, 0);

      mode = 2'd2;
      step(); prev = led_o[0]; tg = 0;
      repeat (32) begin step(); if (led_o[0] != prev) tg++; prev = led_o[0]; end
      chk("blink_tg", tg, 4);

      mode = 2'd3;
      step();
      chk("off", {16'd0, led_o}, 32'd0);
      set_lock(1'b0);
      step(); prev = led_o[0]; tg = 0; bad = 0;
      repeat (32) begin
         step();
         if (led_o[0] != prev) tg++;
         if (led_o != 16'h0 && led_o != 16'hFFFF) bad++;
         prev = led_o[0];
      end
      chk("nolock_tg", tg, 4);
      chk("nolock_allbits", bad, 0);
      set_lock(1'b1);
      repeat (6) step();
      chk("relock", {31'd0, rst_o}, 32'd0);

      sw_i = 16'h0005;
      repeat (12) step();
      chk("sw5", {16'd0, sw_o}, 32'h5);
      set_lock(1'b0);
      repeat (10) step();
      chk("sw5_nolock", {16'd0, sw_o}, 32'h5);
      set_lock(1'b1);

      sw_i = 16'h00F4;
      repeat (5) step();
      arst_n = 1'b0;
      #1 model_reset();
      check_all();
      repeat (2) step();
      arst_n = 1'b1;
      repeat (9) step();
      chk("arst_partial_9", {16'd0, sw_o}, 32'h0);
      step();
      chk("arst_partial_10", {16'd0, sw_o}, 32'hF4);

      hold = 0;
      repeat (400) begin
         if (hold == 0) begin
            sw_i  = 16'($urandom);
            btn_i = 5'($urandom);
            hold  = $urandom_range(1, 14);
         end else hold--;
         led_i  = 16'($urandom);
         bright = 4'($urandom);
         if ($urandom_range(0, 19) == 0) mode = 2'($urandom);
         if (lock && $urandom_range(0, 79) == 0) set_lock(1'b0);
         else if (!lock && $urandom_range(0, 3) == 0) set_lock(1'b1);
         step();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
      $finish;
   end

endmodule
